// File: rtl/systolic_drain.sv
// Output drain for the systolic array: deskews the per-column partial-sum streams
// into aligned row vectors and buffers them in a small FIFO behind a valid/ready port.
module systolic_drain #(
  parameter int COLS       = 4,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [COLS*ACC_WIDTH-1:0]     col_acc,
  input  logic [COLS-1:0]               col_valid,
  input  logic                          clear,
  output logic [COLS*ACC_WIDTH-1:0]     out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          skew_err
);

  localparam int DW = COLS * ACC_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [COLS-1:0] al_v;
  logic [DW-1:0]   al_d;

  // Column c sits COLS-c stages deep so every column lands in the same cycle.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int N = COLS - c;
    logic [N-1:0]         v_q;
    logic [ACC_WIDTH-1:0] d_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int i = 0; i < N; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= clear ? 1'b0 : col_valid[c];
        d_q[0] <= col_acc[c*ACC_WIDTH +: ACC_WIDTH];
        for (int i = 1; i < N; i++) begin
          v_q[i] <= clear ? 1'b0 : v_q[i-1];
          d_q[i] <= d_q[i-1];
        end
      end
    end

    assign al_v[c]                          = v_q[N-1];
    assign al_d[c*ACC_WIDTH +: ACC_WIDTH]   = d_q[N-1];
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_q, level_nx;
  logic          out_valid_q, overflow_q, skew_err_q;
  logic          all_v, skew_hit, full, pop, push, drop;

  always_comb begin
    all_v    = &al_v;
    skew_hit = (|al_v) & ~all_v;
    full     = (level_q == LW'(FIFO_DEPTH));
    pop      = out_valid_q & out_ready;
    push     = all_v & (~full | pop);
    drop     = all_v & full & ~pop;
    level_nx = level_q;
    if (push && !pop)      level_nx = level_q + LW'(1);
    else if (pop && !push) level_nx = level_q - LW'(1);
  end

  // Storage is reset so out_data reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push && !clear) begin
      mem[wr_ptr] <= al_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      skew_err_q  <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      skew_err_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level_q     <= level_nx;
      out_valid_q <= (level_nx != '0);
      overflow_q  <= overflow_q | drop;
      skew_err_q  <= skew_err_q | skew_hit;
    end
  end

  assign out_data  = mem[rd_ptr];
  assign out_valid = out_valid_q;
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign skew_err  = skew_err_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Scoreboard bench for systolic_drain: directed skewed vector streams, monitor pops
// expected vectors whenever the DUT hands one off.
module tb_systolic_drain;
  localparam int COLS = 4;
  localparam int W    = 32;
  localparam int D    = 4;
  localparam int DW   = COLS * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear = 1'b0;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   col_acc = '0;
  logic [COLS-1:0] col_valid = '0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic [2:0]      level;
  logic            overflow, skew_err;

  systolic_drain #(.COLS(COLS), .ACC_WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .col_acc(col_acc), .col_valid(col_valid),
    .clear(clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .overflow(overflow), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0]   sb [$];
  logic [DW-1:0]   exp_v;
  logic [DW-1:0]   sv [8];
  logic [COLS-1:0] sm [8];
  int checks = 0, failures = 0;
  int pops = 0, first_pop = -1, last_pop = -1;
  int c0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int base);
    logic [DW-1:0] r;
    for (int c = 0; c < COLS; c++) r[c*W +: W] = W'(base + c);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Column c carries vector t-c in cycle t.
  task automatic stream(input int n);
    for (int t = 0; t < n + COLS - 1; t++) begin
      for (int c = 0; c < COLS; c++) begin
        int idx;
        idx = t - c;
        if (idx >= 0 && idx < n) begin
          col_acc[c*W +: W] = sv[idx][c*W +: W];
          col_valid[c]      = sm[idx][c];
        end else begin
          col_acc[c*W +: W] = 32'hDEAD_0000 | W'(t);
          col_valid[c]      = 1'b0;
        end
      end
      tick();
    end
    col_valid = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out actual=%0h expected=none", out_data);
      end else begin
        exp_v = sb.pop_front();
        chk("out_data", out_data, exp_v);
      end
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_skew_err", skew_err, 0);
    rst_n = 1'b1;
    tick();

    // single vector, latency
    out_ready = 1'b1;
    sv[0] = {32'd103, 32'd102, 32'd101, 32'd100};
    sm[0] = '1;
    sb.push_back({32'd103, 32'd102, 32'd101, 32'd100});
    pops = 0;
    c0 = cyc;
    fork
      stream(1);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("latency_valid", out_valid, (cyc == c0 + 5));
        end
      end
    join
    chk("t1_pops", pops, 1);
    chk("t1_level", level, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // back-to-back 8 vectors
    for (int k = 0; k < 8; k++) begin
      sv[k] = mk(16 * k);
      sm[k] = '1;
      sb.push_back(mk(16 * k));
    end
    pops = 0;
    first_pop = -1;
    stream(8);
    repeat (8) tick();
    chk("t2_pops", pops, 8);
    chk("t2_consecutive", last_pop - first_pop, 7);
    chk("t2_overflow", overflow, 0);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_level", level, 0);

    // overflow: 5 into depth 4 with no consumer
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sv[k] = mk(200 + 16 * k);
      sm[k] = '1;
      if (k < 4) sb.push_back(mk(200 + 16 * k));
    end
    stream(5);
    repeat (6) tick();
    chk("t3_level_full", level, 4);
    chk("t3_overflow", overflow, 1);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_head_stable", out_data, {32'd203, 32'd202, 32'd201, 32'd200});
    chk("t3_skew_err", skew_err, 0);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t3_sb_empty", sb.size(), 0);
    chk("t3_level_drained", level, 0);
    chk("t3_overflow_sticky", overflow, 1);
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_overflow_cleared", overflow, 0);

    // full FIFO with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      sv[k] = mk(300 + 16 * k);
      sm[k] = '1;
      sb.push_back(mk(300 + 16 * k));
    end
    stream(4);
    repeat (4) tick();
    chk("t4_level_full", level, 4);
    sv[0] = mk(400);
    sm[0] = '1;
    sb.push_back(mk(400));
    fork
      stream(1);
      begin
        repeat (4) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_level_pushpop", level, 4);
        chk("t4_no_overflow", overflow, 0);
      end
    join
    out_ready = 1'b1;
    repeat (8) tick();
    chk("t4_sb_empty", sb.size(), 0);
    chk("t4_level_drained", level, 0);

    // skew: column 2 missing on middle vector
    sv[0] = mk(500); sm[0] = 4'b1111; sb.push_back(mk(500));
    sv[1] = mk(516); sm[1] = 4'b1011;
    sv[2] = mk(532); sm[2] = 4'b1111; sb.push_back(mk(532));
    pops = 0;
    stream(3);
    repeat (6) tick();
    chk("t5_skew_err", skew_err, 1);
    chk("t5_pops", pops, 2);
    chk("t5_sb_empty", sb.size(), 0);
    chk("t5_overflow", overflow, 0);
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_skew_cleared", skew_err, 0);
    chk("t5_level", level, 0);

    // reset mid-stream: 2 in FIFO, 1 in deskew
    for (int k = 0; k < 3; k++) begin
      sv[k] = mk(600 + 16 * k);
      sm[k] = '1;
    end
    fork
      stream(3);
      begin
        repeat (6) tick();
        chk("t6_level_before", level, 2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_data", out_data, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_overflow", overflow, 0);
        chk("t6_rst_skew_err", skew_err, 0);
      end
    join
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    pops = 0;
    repeat (10) tick();
    chk("t6_no_stale_pops", pops, 0);
    chk("t6_level_after", level, 0);
    chk("t6_out_valid_after", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
